scan_display_ctrl: RTL and testbench
====================================

SCAN_DISPLAY_CTRL -- requirements
Module: scan_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 Parameter SCAN_DIV_W, default 15, scan divider width; one digit slot lasts 2**SCAN_DIV_W clk cycles (minimum 4).
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 data  input  4*NUM_DIGITS  hex nibbles; digit 0 = data[4*NUM_DIGITS-1 -: 4] (most significant, leftmost), digit NUM_DIGITS-1 = data[3:0].
REQ-006 dp  input  NUM_DIGITS  decimal point per digit; dp[i] lights the point of digit i.
REQ-007 blank  input  NUM_DIGITS  blank[i]=1 forces digit i dark.
REQ-008 load  input  1  single-cycle strobe capturing data/dp/blank into the pending buffer.
REQ-009 brightness  input  4  duty level; 0 = off, 15 = 15/16 on.
REQ-010 which  output  $clog2(NUM_DIGITS)  index of the digit currently driven.
REQ-011 an_n  output  NUM_DIGITS  one-hot active-low digit enable.
REQ-012 seg  output  8  active-low segments, bit order {ca,cb,cc,cd,ce,cf,cg,cp}, MSB = ca.
REQ-013 pending  output  1  high while the pending buffer holds an update not yet displayed.
REQ-014 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 count (SCAN_DIV_W bits) SHALL increment every cycle and wrap; tick = (count all-ones).
REQ-016 On tick, which SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0 (not to 2**width-1).
REQ-017 Frame boundary = tick while which == NUM_DIGITS-1; frame_done SHALL be high in the following cycle only.
REQ-018 load SHALL write pending buffer and set pending; repeated loads before a boundary overwrite (last wins).
REQ-019 At a frame boundary with pending set, active buffer SHALL take the pending contents and pending SHALL clear in the same edge.
REQ-020 load coincident with a boundary SHALL bypass: active takes the load-cycle inputs directly, pending ends 0.
REQ-021 Displayed content SHALL only change at frame boundaries; no tearing within a frame.
REQ-022 Nibble encoding (active-low, ca..cg, cp=1): 0=0000001,1=1001111,2=0010010,3=0000110,4=1001100,5=0100100,6=0100000,7=0001111,8=0000000,9=0000100,A=0001000,B=1100000,C=0110001,D=1000010,E=0110000,F=0111000.
REQ-023 cp (seg[0]) SHALL be 0 when active dp[which]=1.
REQ-024 Digit enabled when active blank[which]=0 AND count[SCAN_DIV_W-1 -: 4] < brightness; otherwise an_n all ones and seg = 8'hFF.
REQ-025 seg and an_n SHALL be registered: they reflect which/count from the previous cycle (latency 1).

Reset
REQ-026 On rst: count=0, which=0, active and pending buffers 0, pending=0, frame_done=0, an_n all ones, seg=8'hFF.
REQ-027 rst mid-frame or with pending set SHALL discard the pending update; rst overrides a simultaneous load.

Configuration
REQ-028 Macro SCAN_DISPLAY_LZB_EN defined: leading zero digits of the active buffer (index 0 upward, before first nonzero nibble) SHALL be blanked, digit NUM_DIGITS-1 never suppressed, a digit with dp=1 never suppressed and ends suppression.
REQ-029 Macro undefined: no suppression; all digits displayed per REQ-024.

Structure
REQ-030 Package display_pkg SHALL hold SEG_BLANK (8'hFF), the 16-entry segment table constant, and the seg bit-order definition.
REQ-031 Sub-module seg7_decode (nibble + dp -> seg, combinational) SHALL be instantiated once.

Verification
REQ-032 NUM_DIGITS=8, SCAN_DIV_W=4, brightness=15, load data=32'h0123_4567 -> after first boundary, slot i shows hex digit i, e.g. which=0 gives seg=8'b0000_0011 with an_n=8'b1111_1110.
REQ-033 Load 32'hAAAA_AAAA then 32'h5555_5555 within one frame -> only 5's ever displayed, pending clears at the boundary, frame_done pulses once.
REQ-034 load asserted on the boundary cycle -> new value displayed from slot 0 of the next frame, pending=0.
REQ-035 brightness=4, SCAN_DIV_W=6 -> an_n low for exactly 16 of 64 cycles per slot; brightness=0 -> an_n stays all ones.
REQ-036 With SCAN_DISPLAY_LZB_EN, data=32'h0000_0000 -> only digit 7 lit showing '0'; data=32'h0010_0000 -> digits 0-1 dark, digits 2-7 lit.
REQ-037 rst asserted mid-frame with pending=1 -> next cycle which=0, seg=8'hFF, pending=0; old contents never shown.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller.
// Segment byte order is {ca,cb,cc,cd,ce,cf,cg,cp}; ca is the MSB. All segments are active-low.
package display_pkg;

  // Bit positions inside the 8-bit segment byte.
  localparam int SEG_CA = 7;
  localparam int SEG_CB = 6;
  localparam int SEG_CC = 5;
  localparam int SEG_CD = 4;
  localparam int SEG_CE = 3;
  localparam int SEG_CF = 2;
  localparam int SEG_CG = 1;
  localparam int SEG_CP = 0;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {ca..cg} pattern for each hex nibble, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // B
    7'b0110001,  // C
    7'b1000010,  // D
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble + decimal point to active-low segment byte.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Table lookup for ca..cg; the point segment is lit (0) when dp is set.
  always_comb begin
    seg = {SEG_TABLE[nibble], ~dp};
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered content.
// Content captured by load is held pending and only promoted to the displayed
// buffer at a frame boundary, so a frame never mixes old and new digits.
// Optional build macro: SCAN_DISPLAY_LZB_EN enables leading-zero blanking.
module scan_display_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV_W = 15
)
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       data,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         blank,
  input  logic                          load,
  input  logic [3:0]                    brightness,
  output logic [$clog2(NUM_DIGITS)-1:0] which,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [7:0]                    seg,
  output logic                          pending,
  output logic                          frame_done
);

  localparam int WW = $clog2(NUM_DIGITS);
  localparam logic [WW-1:0] LAST = WW'(NUM_DIGITS - 1);

  logic [SCAN_DIV_W-1:0]   r_count;
  logic [WW-1:0]           r_which;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pending;
  logic                    r_frame_done;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an_n;

  logic                    w_tick;
  logic                    w_boundary;
  logic [3:0]              w_nibble;
  logic                    w_dp;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic                    w_lit;
  logic [7:0]              w_seg;

  assign w_tick     = &r_count;
  assign w_boundary = w_tick && (r_which == LAST);

  // Free-running slot divider and digit index; index wraps at the last real digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_which <= '0;
    end else begin
      r_count <= r_count + 1'b1;
      if (w_tick) begin
        r_which <= (r_which == LAST) ? '0 : r_which + 1'b1;
      end
    end
  end

  // Pending/active double buffer; a load on the boundary cycle bypasses straight to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (load) begin
          r_act_data  <= data;
          r_act_dp    <= dp;
          r_act_blank <= blank;
        end else if (r_pending) begin
          r_act_data  <= r_pend_data;
          r_act_dp    <= r_pend_dp;
          r_act_blank <= r_pend_blank;
        end
      end else if (load) begin
        r_pend_data  <= data;
        r_pend_dp    <= dp;
        r_pend_blank <= blank;
        r_pending    <= 1'b1;
      end
    end
  end

  // Select the active nibble/dp/blank of the digit currently being scanned.
  always_comb begin
    w_nibble = '0;
    w_dp     = 1'b0;
    w_blank  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_which == WW'(i)) begin
        w_nibble = r_act_data[4*(NUM_DIGITS-1-i) +: 4];
        w_dp     = r_act_dp[i];
        w_blank  = r_act_blank[i];
      end
    end
  end

`ifdef SCAN_DISPLAY_LZB_EN
  // Suppress zeros from the leftmost digit until a nonzero nibble, a lit point or the last digit.
  always_comb begin
    logic v_run;
    v_run     = 1'b1;
    w_lz_mask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i == NUM_DIGITS - 1) || (r_act_data[4*(NUM_DIGITS-1-i) +: 4] != 4'h0) || r_act_dp[i]) begin
        v_run = 1'b0;
      end
      w_lz_mask[i] = v_run;
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  assign w_lit = !w_blank && !w_lz_mask[r_which] &&
                 (r_count[SCAN_DIV_W-1 -: 4] < brightness);

  seg7_decode u_decode (
    .nibble (w_nibble),
    .dp     (w_dp),
    .seg    (w_seg)
  );

  // Registered drive: segments and enables follow the previous cycle's slot and duty phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg  <= SEG_BLANK;
      r_an_n <= '1;
    end else if (w_lit) begin
      r_seg  <= w_seg;
      r_an_n <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_which);
    end else begin
      r_seg  <= SEG_BLANK;
      r_an_n <= '1;
    end
  end

  assign which      = r_which;
  assign an_n       = r_an_n;
  assign seg        = r_seg;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl: main instance with 16-cycle slots, plus a
// 64-cycle-slot instance sharing the same inputs for the duty-cycle measurement.
module tb_scan_display_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic        load;
  logic [3:0]  brightness;

  logic [2:0]  which,   which_b;
  logic [7:0]  an_n,    an_n_b;
  logic [7:0]  seg,     seg_b;
  logic        pending, pending_b;
  logic        frame_done, fd_b;

  int errors = 0;
  int checks = 0;

  scan_display_ctrl #(.NUM_DIGITS(8), .SCAN_DIV_W(4)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .load(load),
    .brightness(brightness), .which(which), .an_n(an_n), .seg(seg),
    .pending(pending), .frame_done(frame_done)
  );

  scan_display_ctrl #(.NUM_DIGITS(8), .SCAN_DIV_W(6)) dut_b (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .load(load),
    .brightness(brightness), .which(which_b), .an_n(an_n_b), .seg(seg_b),
    .pending(pending_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_frame(input bit use_b, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(use_b ? fd_b : frame_done) && n < 1200);
    checks++;
    if ((use_b ? fd_b : frame_done) !== 1'b1) begin
      errors++;
      $display("FAIL %s: frame_done not seen within %0d cycles", name, n);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    data = d; dp = p; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b1; data = 32'hFFFF_FFFF; dp = 8'hFF; blank = 8'h00;
    brightness = 4'd15;
    repeat (3) @(negedge clk);
    checks++;
    if (which !== 3'd0) begin errors++; $display("FAIL reset_which: got %0d want 0", which); end
    checks++;
    if (an_n !== 8'hFF) begin errors++; $display("FAIL reset_an_n: got %h want ff", an_n); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg); end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending_over_load: got %b want 0", pending); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    load = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_display;
    logic [7:0] exp_seg [8];
    logic [7:0] exp_an;
    exp_seg = '{8'h03, 8'h9F, 8'h25, 8'h0C, 8'h99, 8'hFF, 8'h41, 8'h1F};
    @(negedge clk);
    do_load(32'h0123_4567, 8'b0000_1000, 8'b0010_0000);
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL display_pending_set: got %b want 1", pending); end
    wait_frame(1'b0, "display_frame");
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL display_pending_clear: got %b want 0", pending); end
    for (int i = 0; i < 8; i++) begin
      repeat ((i == 0) ? 1 : 16) @(negedge clk);
      exp_an = (i == 5) ? 8'hFF : ~(8'h01 << i);
      checks++;
      if (which !== 3'(i)) begin errors++; $display("FAIL display_which%0d: got %0d want %0d", i, which, i); end
      checks++;
      if (seg !== exp_seg[i]) begin errors++; $display("FAIL display_seg%0d: got %h want %h", i, seg, exp_seg[i]); end
      checks++;
      if (an_n !== exp_an) begin errors++; $display("FAIL display_an%0d: got %h want %h", i, an_n, exp_an); end
    end
    repeat (14) @(negedge clk);
    checks++;
    if (an_n !== 8'h7F) begin errors++; $display("FAIL display_duty14: got %h want 7f", an_n); end
    @(negedge clk);
    checks++;
    if (an_n !== 8'hFF || seg !== 8'hFF) begin
      errors++; $display("FAIL display_duty15_dark: got an_n=%h seg=%h want ff ff", an_n, seg);
    end
  endtask

  task automatic test_last_wins;
    int fd_cnt, bad, fives;
    wait_frame(1'b0, "lastwins_sync");
    @(negedge clk);
    do_load(32'hAAAA_AAAA, 8'h00, 8'h00);
    do_load(32'h5555_5555, 8'h00, 8'h00);
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL lastwins_pending_set: got %b want 1", pending); end
    wait_frame(1'b0, "lastwins_frame");
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL lastwins_pending_clear: got %b want 0", pending); end
    fd_cnt = 1; bad = 0; fives = 0;
    for (int k = 1; k < 128; k++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (seg == 8'h49) fives++;
      else if (seg != 8'hFF) bad++;
    end
    checks++;
    if (fd_cnt !== 1) begin errors++; $display("FAIL lastwins_fd_pulses: got %0d want 1", fd_cnt); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL lastwins_only_fives: got %0d foreign cycles want 0", bad); end
    checks++;
    if (fives !== 120) begin errors++; $display("FAIL lastwins_five_cycles: got %0d want 120", fives); end
  endtask

  task automatic test_boundary_load;
    wait_frame(1'b0, "bypass_sync");
    repeat (127) @(negedge clk);
    checks++;
    if (seg !== 8'h49 || an_n !== 8'h7F) begin
      errors++; $display("FAIL bypass_old_kept: got seg=%h an_n=%h want 49 7f", seg, an_n);
    end
    do_load(32'hFEDC_BA98, 8'h00, 8'h00);
    checks++;
    if (frame_done !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL bypass_pending: got fd=%b pending=%b want 1 0", frame_done, pending);
    end
    @(negedge clk);
    checks++;
    if (seg !== 8'h71 || an_n !== 8'hFE) begin
      errors++; $display("FAIL bypass_slot0: got seg=%h an_n=%h want 71 fe", seg, an_n);
    end
    repeat (112) @(negedge clk);
    checks++;
    if (seg !== 8'h01 || an_n !== 8'h7F) begin
      errors++; $display("FAIL bypass_slot7: got seg=%h an_n=%h want 01 7f", seg, an_n);
    end
  endtask

  task automatic test_brightness;
    int on_a, on_b;
    wait_frame(1'b1, "bright_sync_b");
    brightness = 4'd4;
    on_a = 0; on_b = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k < 16 && an_n != 8'hFF) on_a++;
      if (an_n_b != 8'hFF) on_b++;
    end
    checks++;
    if (on_a !== 4) begin errors++; $display("FAIL bright4_div4: got %0d of 16 want 4", on_a); end
    checks++;
    if (on_b !== 16) begin errors++; $display("FAIL bright4_div6: got %0d of 64 want 16", on_b); end
    brightness = 4'd0;
    on_a = 0; on_b = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (an_n != 8'hFF) on_a++;
      if (an_n_b != 8'hFF) on_b++;
    end
    checks++;
    if (on_a !== 0 || on_b !== 0) begin
      errors++; $display("FAIL bright0_dark: got %0d and %0d lit want 0 0", on_a, on_b);
    end
    brightness = 4'd15;
  endtask

  task automatic test_zero_digits;
    logic [7:0] exp_seg0, exp_an0;
`ifdef SCAN_DISPLAY_LZB_EN
    exp_seg0 = 8'hFF; exp_an0 = 8'hFF;
`else
    exp_seg0 = 8'h03; exp_an0 = 8'hFE;
`endif
    wait_frame(1'b0, "zero_sync");
    @(negedge clk);
    do_load(32'h0000_0000, 8'h00, 8'h00);
    wait_frame(1'b0, "zero_frame");
    @(negedge clk);
    checks++;
    if (seg !== exp_seg0 || an_n !== exp_an0) begin
      errors++; $display("FAIL zero_digit0: got seg=%h an_n=%h want %h %h", seg, an_n, exp_seg0, exp_an0);
    end
    repeat (112) @(negedge clk);
    checks++;
    if (seg !== 8'h03 || an_n !== 8'h7F) begin
      errors++; $display("FAIL zero_digit7: got seg=%h an_n=%h want 03 7f", seg, an_n);
    end
    do_load(32'h0010_0000, 8'h00, 8'h00);
    wait_frame(1'b0, "lz_frame");
    @(negedge clk);
    checks++;
    if (seg !== exp_seg0 || an_n !== exp_an0) begin
      errors++; $display("FAIL lz_digit0: got seg=%h an_n=%h want %h %h", seg, an_n, exp_seg0, exp_an0);
    end
    repeat (32) @(negedge clk);
    checks++;
    if (seg !== 8'h9F || an_n !== 8'hFB) begin
      errors++; $display("FAIL lz_digit2: got seg=%h an_n=%h want 9f fb", seg, an_n);
    end
  endtask

  task automatic test_reset_midframe;
    int eights, zeros, first_fd;
    wait_frame(1'b0, "rstmid_sync");
    @(negedge clk);
    do_load(32'h8888_8888, 8'h00, 8'h00);
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL rstmid_pending_set: got %b want 1", pending); end
    repeat (37) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (which !== 3'd0 || seg !== 8'hFF || an_n !== 8'hFF) begin
      errors++; $display("FAIL rstmid_outputs: got which=%0d seg=%h an_n=%h want 0 ff ff", which, seg, an_n);
    end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b want 0", pending); end
    eights = 0; zeros = 0; first_fd = -1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (seg == 8'h01) eights++;
      if (seg == 8'h03) zeros++;
      if (frame_done && first_fd < 0) first_fd = k;
    end
    checks++;
    if (eights !== 0) begin errors++; $display("FAIL rstmid_no_old: got %0d cycles of 8 want 0", eights); end
    checks++;
    if (zeros == 0) begin errors++; $display("FAIL rstmid_zeros_shown: got %0d cycles want nonzero", zeros); end
    checks++;
    if (first_fd !== 128) begin errors++; $display("FAIL rstmid_frame_restart: got %0d want 128", first_fd); end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank = '0; brightness = 4'd15;
    test_reset;
    test_display;
    test_last_wins;
    test_boundary_load;
    test_brightness;
    test_zero_digits;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
